// File: rtl/l2_tcdm_pkg.sv
// Shared types, the error-response pattern and address-split helpers for the interleaved L2 TCDM RAM.
package l2_tcdm_pkg;

  // Bus widths used by the default SoC integration of the L2 RAM.
  localparam int TCDM_AW = 32;
  localparam int TCDM_DW = 32;

  typedef struct packed {
    logic [TCDM_AW-1:0]   add;
    logic                 wen;
    logic [TCDM_DW-1:0]   wdata;
    logic [TCDM_DW/8-1:0] be;
  } tcdm_req_t;

  typedef struct packed {
    logic               r_valid;
    logic [TCDM_DW-1:0] r_rdata;
    logic               r_opc;
  } tcdm_rsp_t;

  localparam logic [31:0] ERR_PATTERN = 32'hBADACCE5;

  // Word-interleaved split: [ ... | row | bank | byte offset ]
  function automatic int unsigned bank_idx(input logic [63:0] add, input int ofs, input int bank_bits);
    logic [63:0] s;
    s = (add >> ofs) & ((64'd1 << bank_bits) - 64'd1);
    return 32'(s);
  endfunction

  function automatic int unsigned row_idx(input logic [63:0] add, input int ofs, input int bank_bits,
                                          input int row_bits);
    logic [63:0] s;
    s = (add >> (ofs + bank_bits)) & ((64'd1 << row_bits) - 64'd1);
    return 32'(s);
  endfunction

endpackage

// File: rtl/l2_tcdm_interleaved_ram_bank.sv
// Single-port byte-enabled RAM bank with one-cycle registered read data.
module l2_tcdm_bank #(
  parameter int BANK_WORDS = 8192,
  parameter int DATA_WIDTH = 32,
  localparam int ROW_W = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1,
  localparam int BE_W  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_W-1:0]      row,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_W-1:0]       be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [BANK_WORDS];

  // rdata only moves on a read, so it holds across write cycles.
  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[row];
      end
    end
  end

endmodule

// File: rtl/l2_tcdm_interleaved_ram.sv
// Multi-master, word-interleaved L2 RAM with a round-robin arbiter per bank and 1-cycle responses.
// Define L2_RAM_ADDR_ERR_EN to flag out-of-range accesses (suppressed write, r_opc_o = 1).
module l2_tcdm_interleaved_ram
  import l2_tcdm_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter int NB_BANKS   = 4,
  parameter int BANK_WORDS = 8192,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NB_MASTERS-1:0]                  req_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]  add_i,
  input  logic [NB_MASTERS-1:0]                  wen_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH/8-1:0] be_i,
  output logic [NB_MASTERS-1:0]                  gnt_o,
  output logic [NB_MASTERS-1:0]                  r_valid_o,
  output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  r_rdata_o,
  output logic [NB_MASTERS-1:0]                  r_opc_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int OFS  = $clog2(BE_W);
  localparam int BB   = $clog2(NB_BANKS);
  localparam int RB   = $clog2(BANK_WORDS);
  localparam int BI_W = (BB > 0) ? BB : 1;
  localparam int RB_W = (RB > 0) ? RB : 1;
  localparam int MI_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  typedef struct packed {
    logic [RB_W-1:0]       row;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
    logic                  oor;
  } slv_req_t;

  typedef struct packed {
    logic            vld;
    logic            rd;
    logic            oor;
    logic [BI_W-1:0] bank;
  } rsp_q_t;

  logic     [NB_MASTERS-1:0][BI_W-1:0]       m_bank;
  logic     [NB_MASTERS-1:0]                 m_oor;
  slv_req_t [NB_MASTERS-1:0]                 m_req;
  logic     [NB_BANKS-1:0][NB_MASTERS-1:0]   bank_gnt;
  logic     [NB_BANKS-1:0][DATA_WIDTH-1:0]   bank_rdata;
  rsp_q_t   [NB_MASTERS-1:0]                 rsp_q;
  logic     [DATA_WIDTH-1:0]                 err_word;

  // Address decode per master
  always_comb begin
    for (int m = 0; m < NB_MASTERS; m++) begin
      m_bank[m]      = BI_W'(bank_idx(64'(add_i[m]), OFS, BB));
      m_req[m].row   = RB_W'(row_idx(64'(add_i[m]), OFS, BB, RB));
      m_req[m].wen   = wen_i[m];
      m_req[m].wdata = wdata_i[m];
      m_req[m].be    = be_i[m];
      m_req[m].oor   = m_oor[m];
    end
  end

`ifdef L2_RAM_ADDR_ERR_EN
  localparam int TOP = OFS + BB + RB;
  if (TOP < ADDR_WIDTH) begin : g_oor
    for (genvar m = 0; m < NB_MASTERS; m++) begin : g_m
      assign m_oor[m] = |add_i[m][ADDR_WIDTH-1:TOP];
    end
  end else begin : g_no_oor
    assign m_oor = '0;
  end
`else
  // Upper address bits alias onto the memory.
  assign m_oor = '0;
`endif

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [MI_W-1:0]       rr_ptr;
    logic [MI_W-1:0]       sel;
    logic                  hit;
    logic [NB_MASTERS-1:0] gnt;
    slv_req_t              breq;

    // First requester at or after rr_ptr, searching upward with wrap
    always_comb begin
      int idx;
      gnt = '0;
      sel = '0;
      hit = 1'b0;
      for (int k = 0; k < NB_MASTERS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NB_MASTERS) idx -= NB_MASTERS;
        if (!hit && req_i[idx] && m_bank[idx] == BI_W'(b)) begin
          hit = 1'b1;
          sel = MI_W'(idx);
        end
      end
      if (hit) gnt[sel] = 1'b1;
      breq = m_req[sel];
    end

    assign bank_gnt[b] = gnt & {NB_MASTERS{rst_ni}};

    always_ff @(posedge clk_i) begin
      if (!rst_ni)  rr_ptr <= '0;
      else if (hit) rr_ptr <= (int'(sel) == NB_MASTERS - 1) ? '0 : sel + 1'b1;
    end

    l2_tcdm_bank #(
      .BANK_WORDS(BANK_WORDS),
      .DATA_WIDTH(DATA_WIDTH)
    ) i_bank (
      .clk_i,
      .en    (hit & rst_ni),
      .we    (~breq.wen & ~breq.oor),
      .row   (breq.row),
      .wdata (breq.wdata),
      .be    (breq.be),
      .rdata (bank_rdata[b])
    );
  end

  // A master targets exactly one bank, so OR-ing bank grants never double-grants.
  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NB_BANKS; b++) gnt_o |= bank_gnt[b];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      for (int m = 0; m < NB_MASTERS; m++)
        rsp_q[m] <= '{vld: gnt_o[m], rd: wen_i[m], oor: m_oor[m], bank: m_bank[m]};
    end
  end

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) err_word[i] = ERR_PATTERN[i % 32];
  end

  // Outputs are masked while reset is held so a pending response is dropped.
  always_comb begin
    for (int m = 0; m < NB_MASTERS; m++) begin
      r_valid_o[m] = rsp_q[m].vld & rst_ni;
      r_opc_o[m]   = rsp_q[m].vld & rsp_q[m].oor & rst_ni;
      r_rdata_o[m] = '0;
      if (r_valid_o[m]) begin
        if (rsp_q[m].oor)     r_rdata_o[m] = err_word;
        else if (rsp_q[m].rd) r_rdata_o[m] = bank_rdata[rsp_q[m].bank];
      end
    end
  end

endmodule

// File: doc/l2_tcdm_interleaved_ram.md
Name: l2_tcdm_interleaved_ram

Overview:
- Parametrised successor to the single-bank L2 RAM behind the JTAG lint master.
- Serves NB_MASTERS TCDM-style masters (JTAG lint, debug, DMA) from NB_BANKS word-interleaved banks.
- Each bank has its own round-robin arbiter, so masters hitting different banks proceed in parallel. Response latency is fixed at one cycle.

Parameters:
- NB_MASTERS, 2: number of TCDM master ports, at least 1.
- NB_BANKS, 4: number of interleaved banks; a power of 2, at least 1.
- BANK_WORDS, 8192: words per bank; a power of 2.
- DATA_WIDTH, 32: word width in bits; a multiple of 8.
- ADDR_WIDTH, 32: byte-address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Synchronous, active-low, sampled on the rising edge of clk_i.
- req_i  in  NB_MASTERS  request, one bit per master.
- add_i  in  NB_MASTERS x ADDR_WIDTH  byte address.
- wen_i  in  NB_MASTERS  1 = read, 0 = write (TCDM convention).
- wdata_i  in  NB_MASTERS x DATA_WIDTH  write data.
- be_i  in  NB_MASTERS x DATA_WIDTH/8  byte enables.
- gnt_o  out  NB_MASTERS  grant; combinational from req_i and arbiter state.
- r_valid_o  out  NB_MASTERS  response valid.
- r_rdata_o  out  NB_MASTERS x DATA_WIDTH  read data.
- r_opc_o  out  NB_MASTERS  error flag; see Optional Feature.

Behaviour:
- Address split:
  - OFS = log2(DATA_WIDTH/8).
  - Bank index = add[OFS +: log2(NB_BANKS)]; with NB_BANKS = 1 the bank index is 0.
  - Row = add[OFS+log2(NB_BANKS) +: log2(BANK_WORDS)].
  - Low OFS bits are ignored.
- Arbitration, per bank, combinational:
  - Among masters with req_i = 1 targeting the bank, grant the first at or after rr_ptr[bank], searching upward with wrap.
  - At most one grant per bank per cycle. A master is never granted by two banks.
- Round-robin pointer update: on any grant for a bank, rr_ptr[bank] <= granted index + 1, modulo NB_MASTERS. With no grant the pointer holds.
- Request holding: a master holds req, add, wen, wdata and be stable until gnt. The block does not check this.
- Write access: the granted write updates only the bytes with be = 1 at the clock edge.
- Read access: the granted read samples the row at the clock edge and returns its data in the next cycle.
- Response timing: a grant in cycle N gives r_valid_o = 1 in cycle N+1 for exactly one cycle.
  - Reads return the row data.
  - Writes return r_valid with r_rdata = 0.
  - r_valid_o is never asserted without a prior grant.
- Back-to-back: a master may be granted every cycle. Each response is independent; there is no buffering beyond one stage per master.
- Read-after-write, same row, consecutive cycles: the read sees the written data. The write commits at edge N and the read samples at edge N+1.
- Reset values:
  - While rst_ni = 0: gnt_o = 0 (grants masked), and r_valid_o, r_rdata_o, r_opc_o are 0.
  - Registers cleared at the reset edge: rr_ptr = 0, response stage cleared.
  - Memory contents are not cleared.
- Reset mid-operation: any response pending for cycle N+1 is dropped. A write granted in the reset cycle is not performed.
- No internal state machine beyond the arbiter pointers and the response pipeline.

Optional Feature:
- Macro: L2_RAM_ADDR_ERR_EN.
- With the macro defined:
  - Out-of-range access: byte addresses at or above NB_BANKS*BANK_WORDS*DATA_WIDTH/8 are still arbitrated and granted.
  - Writes are suppressed.
  - The response carries r_opc_o = 1 and r_rdata_o = 32'hBADACCE5, replicated or truncated to DATA_WIDTH.
- Without the macro: upper address bits are ignored, so the address aliases modulo the memory size, and r_opc_o is tied to 0.

Decomposition:
- Package l2_tcdm_pkg holds:
  - typedef tcdm_req_t {add, wen, wdata, be};
  - typedef tcdm_rsp_t {r_valid, r_rdata, r_opc};
  - localparam ERR_PATTERN = 32'hBADACCE5;
  - functions bank_idx() and row_idx().
- Sub-module l2_tcdm_bank: single-port byte-enabled RAM, one per bank, with 1-cycle read latency and a generate-time BANK_WORDS/DATA_WIDTH.
- Arbiters and the response pipe stay in the top.

Test Plan:
- Single write then read (master 0, bank 0):
  - Master 0 writes 0xDEADBEEF with be = 4'hF to 0x0000_0000, then reads it.
  - Required: gnt in the request cycle; read r_valid one cycle later with rdata = 0xDEADBEEF.
- Interleave:
  - Master 0 writes 0x11 to 0x00 and master 1 writes 0x22 to 0x04 in the same cycle.
  - Required: both granted in the same cycle (banks 0 and 1); reads return 0x11 and 0x22.
- Conflict fairness:
  - Both masters continuously request address 0x10 for 4 cycles.
  - Required: grants alternate M0, M1, M0, M1; each r_valid arrives one cycle after its grant.
- Byte enables:
  - Write 0xAABBCCDD with be = 4'b0101 to a row holding 0x0.
  - Required: a read returns 0x00BB00DD.
- Reset mid-operation:
  - Assert rst_ni = 0 in the cycle after a read grant.
  - Required: no r_valid; gnt = 0 while reset is held; rr_ptr = 0 afterwards; memory contents retained.
- Out-of-range address 0x0002_0000 (defaults: 128 KiB):
  - With L2_RAM_ADDR_ERR_EN: r_opc = 1, rdata = 0xBADACCE5, and row 0 is unchanged.
  - Without the macro: the access aliases to row 0 of bank 0.
